control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that sits directly upstream of `datapath`.
- Steps through fetch (T0-T2) and execute (T3-T6) for register-format ALU ops, mul/div, nop and halt.
- Drives the datapath's strobe inputs plus Gra/Grb/Grc/Rin/Rout, which feed the select-and-encode logic.
- Reads the instruction back from the datapath's IR.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- OP_MUL, 5'b01111, multiply opcode.
- OP_DIV, 5'b10000, divide opcode.
- OP_NOP, 5'b11000, no-operation opcode.
- OP_HALT, 5'b11001, halt opcode.
- OP_RLO, 5'b00011 / OP_RHI, 5'b01100, inclusive range of register-format ALU opcodes.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset.
- IR  in  32  instruction register contents from datapath.
- stop  in  1  halt request.
- PCout, incPC, MARin, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register select/enable to select-and-encode.
- opcode  out  OPW  ALU operation code.
- run  out  1  high while executing.
- illegal  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset: one clock, clk. Reset clr is synchronous and active-high: clr=1 at a posedge loads RESET_ST.
- RESET_ST outputs: every output 0, run=0, illegal=0. This applies mid-instruction too; no partial step completes.
- Output timing: all outputs decode combinationally from the state register only (Moore). Each step lasts exactly one clock; the datapath latches at the posedge that ends the step.
- Unlisted outputs are 0 in every step. opcode=0 outside T4.
- States: RESET_ST, T0, T1, T2, T3, T4, T5, T6, HALT.
- RESET_ST -> T0 if stop=0, else HALT.
- T0: PCout, MARin, incPC, Zin.
- T1: ZLowOut, PCin, Read, MDRin.
- T2: MDRout, IRin. Next state is decoded from IR[31:27] in T3, since IR is valid from T3 onward.
- Register-format ALU op (OP_RLO..OP_RHI):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, opcode=IR[31:27].
  - T5: ZLowOut, Gra, Rin.
  - 6 cycles per instruction.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, opcode=IR[31:27].
  - T5: ZLowOut, LOin.
  - T6: ZHighOut, HIin.
  - 7 cycles per instruction.
- nop: T3 has no strobes; 4 cycles per instruction.
- halt: T3 -> HALT.
- End of instruction: the last step goes to T0 if stop=0, else HALT. stop is sampled only at instruction boundaries; a request mid-instruction lets that instruction finish.
- HALT: all strobes 0, run=0. Held until clr; stop deassertion does not resume.
- run=1 in T0-T6.
- Illegal opcode (any value not listed above): treated as nop unless ILLEGAL_TRAP_EN is defined.
- Exactly one of Gra/Grb/Grc is high whenever Rin or Rout is high.
- Rin and Rout are never high together.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in T3 asserts no strobes and next goes HALT. illegal=1 while in HALT until clr.
- Undefined: an illegal opcode behaves exactly as nop. illegal is tied to 0.

Test Plan:
- Reset: clr=1 for 2 cycles, then 0 with stop=0 -> one RESET_ST cycle with all outputs 0, then T0 with PCout=MARin=incPC=Zin=1 and run=1. Next T1 has ZLowOut=PCin=Read=MDRin=1; T2 has MDRout=IRin=1.
- ALU op: IR=0x2A2B0000 (opcode 00101) -> T3 Grb=Rout=Yin=1; T4 Grc=Rout=Zin=1 with opcode=5'b00101; T5 Gra=Rin=ZLowOut=1; T0 re-entered 6 cycles after the previous T0.
- mul: IR opcode 01111 -> T4 opcode=5'b01111; T5 LOin=ZLowOut=1; T6 HIin=ZHighOut=1; next T0 7 cycles after the previous T0. Repeat for div (10000) with the same timing.
- nop/halt: opcode 11000 -> T0 re-entered after 4 cycles. Then opcode 11001 -> HALT after T3; run=0 and all strobes 0 for 20 cycles; resumes only after clr.
- Stop and reset: stop=1 pulsed one cycle during T4 of an ALU op -> T5 completes, then HALT. Separately, clr=1 during T4 -> next cycle RESET_ST, Rin never asserted.
- Illegal opcode 10101: with ILLEGAL_TRAP_EN -> HALT after T3 with illegal=1. Without it -> T0 after 4 cycles with illegal=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer driving the datapath strobes for fetch/execute.
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes halt and raise `illegal` instead of acting as nop.
module control_sequencer #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] OP_MUL  = 5'b01111,
  parameter logic [OPW-1:0] OP_DIV  = 5'b10000,
  parameter logic [OPW-1:0] OP_NOP  = 5'b11000,
  parameter logic [OPW-1:0] OP_HALT = 5'b11001,
  parameter logic [OPW-1:0] OP_RLO  = 5'b00011,
  parameter logic [OPW-1:0] OP_RHI  = 5'b01100
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    IR,
  input  logic           stop,
  output logic           PCout,
  output logic           incPC,
  output logic           MARin,
  output logic           Zin,
  output logic           ZLowOut,
  output logic           ZHighOut,
  output logic           PCin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] opcode,
  output logic           run,
  output logic           illegal
);

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    T0       = 4'd1,
    T1       = 4'd2,
    T2       = 4'd3,
    T3       = 4'd4,
    T4       = 4'd5,
    T5       = 4'd6,
    T6       = 4'd7,
    HALT     = 4'd8
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  state_t         done_next;
  logic           stop_pend_reg;
  logic [OPW-1:0] op;
  logic           is_alu;
  logic           is_muldiv;
  logic           is_halt;
  logic           ir_unused;

  // IR is stable from T3 until the next fetch, so execute steps decode it directly.
  assign op        = IR[31 -: OPW];
  assign ir_unused = ^IR[31-OPW:0];
  assign is_alu    = (op >= OP_RLO) && (op <= OP_RHI);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_halt   = (op == OP_HALT);

`ifdef ILLEGAL_TRAP_EN
  logic is_illegal;
  logic trap;
  logic illegal_reg;

  assign is_illegal = !(is_alu || is_muldiv || is_halt || (op == OP_NOP));
  assign trap       = (state_reg == T3) && is_illegal;

  always_ff @(posedge clk) begin
    if (clr) begin
      illegal_reg <= 1'b0;
    end else if (trap) begin
      illegal_reg <= 1'b1;
    end
  end

  assign illegal = illegal_reg && (state_reg == HALT);
`else
  assign illegal = 1'b0;
`endif

  // A stop request is remembered so a one-cycle pulse mid-instruction still halts at the boundary.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= RESET_ST;
      stop_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (stop) begin
        stop_pend_reg <= 1'b1;
      end
    end
  end

  assign done_next = (stop || stop_pend_reg) ? HALT : T0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RESET_ST: state_next = done_next;
      T0:       state_next = T1;
      T1:       state_next = T2;
      T2:       state_next = T3;
      T3: begin
        if (is_alu || is_muldiv) begin
          state_next = T4;
        end else if (is_halt) begin
          state_next = HALT;
`ifdef ILLEGAL_TRAP_EN
        end else if (trap) begin
          state_next = HALT;
`endif
        end else begin
          state_next = done_next;
        end
      end
      T4:       state_next = T5;
      T5:       state_next = is_muldiv ? T6 : done_next;
      T6:       state_next = done_next;
      HALT:     state_next = HALT;
      default:  state_next = RESET_ST;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    incPC    = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    opcode   = '0;
    run      = 1'b0;
    case (state_reg)
      T0: begin
        run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        run     = 1'b1;
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        run = 1'b1;
        // ALU ops stage rb into Y; mul/div stage ra; nop/halt/illegal strobe nothing.
        if (is_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_muldiv) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      T4: begin
        run    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        opcode = op;
        if (is_muldiv) begin
          Grb = 1'b1;
        end else begin
          Grc = 1'b1;
        end
      end
      T5: begin
        run     = 1'b1;
        ZLowOut = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      T6: begin
        run      = 1'b1;
        ZHighOut = 1'b1;
        HIin     = 1'b1;
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

  rin_rout_exclusive: assert property (@(posedge clk) disable iff (clr) !(Rin && Rout));
  reg_select_onehot:  assert property (@(posedge clk) disable iff (clr)
                                       (Rin || Rout) |-> $onehot({Gra, Grb, Grc}));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-step output words compared against
// an instruction-level model; honours ILLEGAL_TRAP_EN when defined for the build.
module tb_control_sequencer;

  typedef logic [25:0] word_t;

  localparam int P_ROUT = 0,  P_RIN = 1,   P_GRC = 2,    P_GRB = 3,    P_GRA = 4;
  localparam int P_LOIN = 5,  P_HIIN = 6,  P_YIN = 7,    P_IRIN = 8,   P_MDROUT = 9;
  localparam int P_MDRIN = 10, P_READ = 11, P_PCIN = 12, P_ZHIGH = 13, P_ZLOW = 14;
  localparam int P_ZIN = 15,  P_MARIN = 16, P_INCPC = 17, P_PCOUT = 18;
  localparam int P_OPC = 19,  P_RUN = 24,  P_ILL = 25;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic PCout, incPC, MARin, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, run, illegal;
  logic [4:0] opcode;

  int    n_checks = 0;
  int    n_fail = 0;
  word_t exp_q[$];
  bit    model_halts;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(ir), .stop(stop),
    .PCout(PCout), .incPC(incPC), .MARin(MARin), .Zin(Zin), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .opcode(opcode), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic word_t b(input int pos);
    return word_t'(1) << pos;
  endfunction

  function automatic word_t pack_out();
    return {illegal, run, opcode, PCout, incPC, MARin, Zin, ZLowOut, ZHighOut, PCin, Read,
            MDRin, MDRout, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout};
  endfunction

  // Expected per-cycle output words for one instruction starting at T0, followed by
  // halt_len HALT cycles when the instruction ends the run.
  task automatic model_instr(input logic [31:0] ir_v, input int stop_at, input int halt_len);
    logic [4:0] op;
    bit alu, md, ill, stop_req;
    word_t w_run, hw;
    op    = ir_v[31:27];
    alu   = (op >= 5'd3) && (op <= 5'd12);
    md    = (op == 5'd15) || (op == 5'd16);
    ill   = !(alu || md || op == 5'd24 || op == 5'd25);
    w_run = b(P_RUN);
    exp_q.delete();
    exp_q.push_back(w_run | b(P_PCOUT) | b(P_MARIN) | b(P_INCPC) | b(P_ZIN));
    exp_q.push_back(w_run | b(P_ZLOW) | b(P_PCIN) | b(P_READ) | b(P_MDRIN));
    exp_q.push_back(w_run | b(P_MDROUT) | b(P_IRIN));
    if (alu) begin
      exp_q.push_back(w_run | b(P_GRB) | b(P_ROUT) | b(P_YIN));
      exp_q.push_back(w_run | b(P_GRC) | b(P_ROUT) | b(P_ZIN) | (word_t'(op) << P_OPC));
      exp_q.push_back(w_run | b(P_ZLOW) | b(P_GRA) | b(P_RIN));
    end else if (md) begin
      exp_q.push_back(w_run | b(P_GRA) | b(P_ROUT) | b(P_YIN));
      exp_q.push_back(w_run | b(P_GRB) | b(P_ROUT) | b(P_ZIN) | (word_t'(op) << P_OPC));
      exp_q.push_back(w_run | b(P_ZLOW) | b(P_LOIN));
      exp_q.push_back(w_run | b(P_ZHIGH) | b(P_HIIN));
    end else begin
      exp_q.push_back(w_run);
    end
    stop_req    = (stop_at >= 0) && (stop_at < exp_q.size());
    model_halts = (op == 5'd25) || (ill && TRAP) || stop_req;
    hw          = (ill && TRAP) ? b(P_ILL) : word_t'(0);
    if (model_halts) begin
      repeat (halt_len) exp_q.push_back(hw);
    end
  endtask

  task automatic test_reset();
    word_t obs;
    clr = 1'b1;
    stop = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== word_t'(0)) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got %h expected %h", c, obs, word_t'(0));
      end
    end
    clr = 1'b0;
    model_instr({5'b11000, 27'h0}, -1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_fetch step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
      if (i == 0) ir = {5'b11000, 27'h0};
      stop = 1'b0;
    end
    $display("reset: fetch sequence after clr checked");
  endtask

  task automatic test_alu();
    logic [31:0] irs[4];
    word_t obs;
    irs[0] = 32'h2A2B0000;
    irs[1] = {5'b00011, 27'($urandom)};
    irs[2] = {5'b01100, 27'($urandom)};
    irs[3] = {5'($urandom_range(3, 12)), 27'($urandom)};
    for (int k = 0; k < 4; k++) begin
      model_instr(irs[k], -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        obs = pack_out();
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL alu[%0d] step %0d: got %h expected %h", k, i, obs, exp_q[i]);
        end
        if (i == 0) ir = irs[k];
        stop = 1'b0;
      end
      $display("alu ir=%08h steps=%0d", irs[k], exp_q.size());
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] irs[2];
    word_t obs;
    irs[0] = {5'b01111, 27'($urandom)};
    irs[1] = {5'b10000, 27'($urandom)};
    for (int k = 0; k < 2; k++) begin
      model_instr(irs[k], -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        obs = pack_out();
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL muldiv[%0d] step %0d: got %h expected %h", k, i, obs, exp_q[i]);
        end
        if (i == 0) ir = irs[k];
        stop = 1'b0;
      end
      $display("muldiv ir=%08h steps=%0d", irs[k], exp_q.size());
    end
  endtask

  task automatic test_nop_halt();
    logic [31:0] irs[2];
    word_t obs;
    irs[0] = {5'b11000, 27'($urandom)};
    irs[1] = {5'b11001, 27'($urandom)};
    for (int k = 0; k < 2; k++) begin
      model_instr(irs[k], -1, 20);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        obs = pack_out();
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL nop_halt[%0d] step %0d: got %h expected %h", k, i, obs, exp_q[i]);
        end
        if (i == 0) ir = irs[k];
        stop = 1'b0;
      end
      $display("nop_halt ir=%08h cycles=%0d", irs[k], exp_q.size());
    end
    clr = 1'b1;
    @(negedge clk);
    obs = pack_out();
    n_checks++;
    if (obs !== word_t'(0)) begin
      n_fail++;
      $display("FAIL halt_clr_reset: got %h expected %h", obs, word_t'(0));
    end
    clr = 1'b0;
  endtask

  task automatic test_stop();
    logic [31:0] irv;
    word_t obs;
    irv = {5'($urandom_range(3, 12)), 27'($urandom)};
    model_instr(irv, 4, 5);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stop_mid step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
      if (i == 0) ir = irv;
      stop = (i == 4);
    end
    $display("stop pulsed at T4 ir=%08h", irv);
    clr = 1'b1;
    stop = 1'b0;
    @(negedge clk);
    obs = pack_out();
    n_checks++;
    if (obs !== word_t'(0)) begin
      n_fail++;
      $display("FAIL stop_clr_reset: got %h expected %h", obs, word_t'(0));
    end
    clr = 1'b0;
  endtask

  task automatic test_clr_mid();
    logic [31:0] irv;
    word_t obs;
    irv = {5'($urandom_range(3, 12)), 27'($urandom)};
    model_instr(irv, -1, 0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL clr_mid step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
      if (i == 0) ir = irv;
      stop = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    obs = pack_out();
    n_checks++;
    if (obs !== word_t'(0)) begin
      n_fail++;
      $display("FAIL clr_mid_reset (Rin=%0b): got %h expected %h", Rin, obs, word_t'(0));
    end
    clr = 1'b0;
    $display("clr during T4 ir=%08h", irv);
  endtask

  task automatic test_illegal();
    logic [31:0] irv;
    word_t obs;
    irv = {5'b10101, 27'($urandom)};
    model_instr(irv, -1, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
      if (i == 0) ir = irv;
      stop = 1'b0;
    end
    $display("illegal ir=%08h halted=%0d", irv, model_halts);
    if (model_halts) begin
      clr = 1'b1;
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== word_t'(0)) begin
        n_fail++;
        $display("FAIL illegal_clr_reset: got %h expected %h", obs, word_t'(0));
      end
      clr = 1'b0;
    end
  endtask

  task automatic test_reset_stop();
    word_t obs;
    clr = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    obs = pack_out();
    n_checks++;
    if (obs !== word_t'(0)) begin
      n_fail++;
      $display("FAIL reset_stop_reset: got %h expected %h", obs, word_t'(0));
    end
    clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      obs = pack_out();
      n_checks++;
      if (obs !== word_t'(0)) begin
        n_fail++;
        $display("FAIL reset_stop_halt cycle %0d: got %h expected %h", c, obs, word_t'(0));
      end
      stop = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    obs = pack_out();
    n_checks++;
    if (obs !== word_t'(0)) begin
      n_fail++;
      $display("FAIL reset_stop_clr: got %h expected %h", obs, word_t'(0));
    end
    clr = 1'b0;
    $display("stop during reset goes straight to HALT");
  endtask

  task automatic test_back_to_back();
    logic [31:0] irv;
    logic [4:0]  op;
    int          stop_at;
    word_t       obs;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 5'($urandom_range(3, 12));
        4:          op = 5'd15;
        5:          op = 5'd16;
        6:          op = 5'd24;
        7:          op = ($urandom_range(0, 3) == 0) ? 5'd25 : 5'd24;
        default:    op = 5'($urandom_range(0, 31));
      endcase
      irv = {op, 27'($urandom)};
      stop_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
      model_instr(irv, stop_at, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        obs = pack_out();
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b[%0d] step %0d: got %h expected %h", t, i, obs, exp_q[i]);
        end
        if (i == 0) ir = irv;
        stop = (i == stop_at);
      end
      $display("txn %0d ir=%08h stop_at=%0d halted=%0d", t, irv, stop_at, model_halts);
      if (model_halts) begin
        clr = 1'b1;
        stop = 1'b0;
        @(negedge clk);
        obs = pack_out();
        n_checks++;
        if (obs !== word_t'(0)) begin
          n_fail++;
          $display("FAIL b2b_clr[%0d]: got %h expected %h", t, obs, word_t'(0));
        end
        clr = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_muldiv();
    test_nop_halt();
    test_stop();
    test_clr_mid();
    test_illegal();
    test_reset_stop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
